// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch encodings, fetch FSM states, reset PC and link register.
package mips_pkg;

    localparam logic [2:0] BT_BEQ  = 3'd0;
    localparam logic [2:0] BT_BNE  = 3'd1;
    localparam logic [2:0] BT_BGEZ = 3'd2;
    localparam logic [2:0] BT_BGTZ = 3'd3;
    localparam logic [2:0] BT_BLEZ = 3'd4;
    localparam logic [2:0] BT_BLTZ = 3'd5;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_RST   = 2'd0;
    localparam fsm_state_t ST_FETCH = 2'd1;
    localparam fsm_state_t ST_EXEC  = 2'd2;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [4:0]  LINK_REG = 5'd31;

    // Branch displacement: sign-extended immediate scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_branch_cmp.sv
// Combinational taken-condition evaluator for conditional branches.
module branch_cmp
    import mips_pkg::*;
(
    input  logic [2:0]  branch_type,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken
);

    logic rs_neg_s;
    logic rs_zero_s;

    assign rs_neg_s  = rs_data[31];
    assign rs_zero_s = (rs_data == 32'h0000_0000);

    // Decode the branch condition; unused encodings never branch.
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BT_BEQ:  taken = (rs_data == rt_data);
            BT_BNE:  taken = (rs_data != rt_data);
            BT_BGEZ: taken = !rs_neg_s;
            BT_BGTZ: taken = !rs_neg_s && !rs_zero_s;
            BT_BLEZ: taken = rs_neg_s || rs_zero_s;
            BT_BLTZ: taken = rs_neg_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: memory handshake, instruction register,
// next-PC selection and the link write for JAL/JALR.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        stall,
    input  logic        Branch,
    input  logic [2:0]  branch_type,
    input  logic        Jump,
    input  logic        JumpDst,
    input  logic        JumpLink,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] pc,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data
);

    fsm_state_t  state_r;
    logic [31:0] pc_r;
    logic [31:0] ins_r;
    logic [31:0] pc4_s;
    logic [31:0] next_pc_s;
    logic        taken_s;
    logic        retire_s;
    logic        unused_opcode_s;

    branch_cmp u_branch_cmp (
        .branch_type (branch_type),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .taken       (taken_s)
    );

    assign pc4_s           = pc_r + 32'd4;
    assign retire_s        = (state_r == ST_EXEC) && !stall;
    assign unused_opcode_s = ^ins_r[31:26];

    // Next-PC priority: register jump, absolute jump, taken branch, sequential.
    always_comb begin
        next_pc_s = pc4_s;
        if (Jump && JumpDst) begin
            next_pc_s = {rs_data[31:2], 2'b00};
        end else if (Jump) begin
            next_pc_s = {pc4_s[31:28], ins_r[25:0], 2'b00};
        end else if (Branch && taken_s) begin
            next_pc_s = pc4_s + branch_offset(ins_r[15:0]);
        end else begin
            next_pc_s = pc4_s;
        end
    end

    // Fetch FSM, PC and instruction register; a late ack seen in RST is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RST;
            pc_r    <= RESET_PC_P;
            ins_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_RST: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ins_r   <= imem_rdata;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc_r    <= next_pc_s;
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
        end
    end

    assign imem_req  = (state_r == ST_FETCH);
    assign imem_addr = pc_r;
    assign ins       = ins_r;
    assign ins_valid = (state_r == ST_EXEC);
    assign pc        = pc_r;
    assign link_we   = JumpLink && retire_s;
    assign link_data = pc4_s;

    // JALR names its destination in rd; JAL always links to r31.
    always_comb begin
        link_addr = 5'd0;
        if (link_we) begin
            link_addr = JumpDst ? ins_r[15:11] : LINK_REG;
        end else begin
            link_addr = 5'd0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic        stall;
    logic        Branch;
    logic [2:0]  branch_type;
    logic        Jump;
    logic        JumpDst;
    logic        JumpLink;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .stall       (stall),
        .Branch      (Branch),
        .branch_type (branch_type),
        .Jump        (Jump),
        .JumpDst     (JumpDst),
        .JumpLink    (JumpLink),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .pc          (pc),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .link_data   (link_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] pcv, input logic [31:0] insv,
                                             input logic br, input logic [2:0] bt,
                                             input logic j, input logic jd,
                                             input logic [31:0] rs, input logic [31:0] rt);
        longint      srs;
        bit          tk;
        int          off;
        logic [31:0] p4;
        srs = $signed(rs);
        p4  = pcv + 32'd4;
        off = int'($signed(insv[15:0])) * 4;
        case (bt)
            3'd0:    tk = (rs == rt);
            3'd1:    tk = (rs != rt);
            3'd2:    tk = (srs >= 0);
            3'd3:    tk = (srs > 0);
            3'd4:    tk = (srs <= 0);
            3'd5:    tk = (srs < 0);
            default: tk = 1'b0;
        endcase
        if (j && jd)      return {rs[31:2], 2'b00};
        else if (j)       return {p4[31:28], insv[25:0], 2'b00};
        else if (br && tk) return p4 + 32'(off);
        else              return p4;
    endfunction

    task automatic clear_ctrl();
        Branch = 1'b0; branch_type = 3'd0; Jump = 1'b0; JumpDst = 1'b0; JumpLink = 1'b0;
        stall = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
    endtask

    task automatic wait_fetch();
        for (int i = 0; i < 12 && imem_req !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_timeout: imem_req=%b want 1", imem_req);
        end
    endtask

    // One instruction: delayed fetch, optional stall cycles, retire, then next-PC check.
    task automatic run_instr(input int delay, input logic [31:0] word,
                             input logic br, input logic [2:0] bt,
                             input logic j, input logic jd, input logic jl,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input int stalls, input bit use_want, input logic [31:0] want);
        logic [31:0] nxt;
        logic [31:0] prev_ins;
        wait_fetch();
        prev_ins = ins;
        for (int k = 0; k < delay; k++) begin
            imem_ack = 1'b0; imem_rdata = $urandom; stall = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || ins !== prev_ins || ins_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_wait: req=%b addr=%h ins=%h want req=1 addr=%h ins=%h",
                         imem_req, imem_addr, ins, exp_pc, prev_ins);
            end
            @(negedge clk);
        end
        imem_ack = 1'b1; imem_rdata = word; stall = 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL fetch_ack: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc);
        end
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        Branch = br; branch_type = bt; Jump = j; JumpDst = jd; JumpLink = jl;
        rs_data = rs; rt_data = rt;
        nxt = use_want ? want : ref_next(exp_pc, word, br, bt, j, jd, rs, rt);
        n_checks++;
        if (ins_valid !== 1'b1 || ins !== word || pc !== exp_pc) begin
            n_fail++;
            $display("FAIL exec_entry: valid=%b ins=%h pc=%h want 1 %h %h", ins_valid, ins, pc, word, exp_pc);
        end
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            #1;
            n_checks++;
            if (link_we !== 1'b0 || ins_valid !== 1'b1 || pc !== exp_pc) begin
                n_fail++;
                $display("FAIL stall_hold: link_we=%b valid=%b pc=%h want 0 1 %h", link_we, ins_valid, pc, exp_pc);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (link_we !== jl) begin
            n_fail++;
            $display("FAIL link_we: got %b want %b", link_we, jl);
        end
        if (jl) begin
            n_checks++;
            if (link_addr !== (jd ? word[15:11] : 5'd31) || link_data !== exp_pc + 32'd4) begin
                n_fail++;
                $display("FAIL link_write: addr=%0d data=%h want %0d %h", link_addr, link_data,
                         jd ? word[15:11] : 5'd31, exp_pc + 32'd4);
            end
        end
        @(negedge clk);
        exp_pc = nxt;
        n_checks++;
        if (pc !== exp_pc || imem_req !== 1'b1 || ins_valid !== 1'b0 || link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL next_pc: pc=%h req=%b valid=%b link_we=%b want %h 1 0 0",
                     pc, imem_req, ins_valid, link_we, exp_pc);
        end
        clear_ctrl();
    endtask

    task automatic go_to(input logic [31:0] target);
        run_instr(0, 32'h0000_0008, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, target, 32'h0, 0, 1'b1,
                  {target[31:2], 2'b00});
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; clear_ctrl();
        repeat (2) @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0 || link_we !== 1'b0 || link_addr !== 5'd0 ||
            pc !== RESET_PC || ins !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b lwe=%b laddr=%0d pc=%h ins=%h want 0 0 0 0 %h 0",
                     imem_req, ins_valid, link_we, link_addr, pc, ins, RESET_PC);
        end
        rst = 1'b0;
        exp_pc = RESET_PC;
    endtask

    task automatic test_basic();
        test_reset();
        run_instr(0, 32'h2008_0005, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h4);
    endtask

    task automatic test_delayed_ack();
        test_reset();
        run_instr(3, 32'h2009_0007, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h4);
    endtask

    task automatic test_branches();
        go_to(32'h10);
        run_instr(1, 32'h1022_FFFC, 1'b1, BT_BEQ, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7, 0, 1'b1, 32'h04);
        go_to(32'h10);
        run_instr(0, 32'h1022_FFFC, 1'b1, BT_BEQ, 1'b0, 1'b0, 1'b0, 32'd7, 32'd8, 0, 1'b1, 32'h14);
        go_to(32'h100);
        run_instr(0, 32'h0420_0008, 1'b1, BT_BLTZ, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1, 1'b1, 32'h124);
        go_to(32'h100);
        run_instr(0, 32'h0421_0008, 1'b1, BT_BGEZ, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 0, 1'b1, 32'h104);
        go_to(32'h100);
        run_instr(2, 32'h1820_0008, 1'b1, BT_BLEZ, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h124);
        go_to(32'h100);
        run_instr(0, 32'h1020_0008, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 0, 1'b1, 32'h104);
    endtask

    task automatic test_jal();
        go_to(32'h0040_0020);
        run_instr(0, 32'h0C00_0010, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b1, 32'h0000_0040);
    endtask

    task automatic test_jalr_stall();
        go_to(32'h200);
        run_instr(0, 32'h0020_2809, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h1003, 32'h0, 2, 1'b1, 32'h1000);
        go_to(32'h200);
        wait_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h0020_2809;
        @(negedge clk);
        imem_ack = 1'b0;
        Jump = 1'b1; JumpDst = 1'b1; JumpLink = 1'b1; rs_data = 32'h1003;
        for (int s = 0; s < 2; s++) begin
            stall = 1'b1;
            #1;
            n_checks++;
            if (link_we !== 1'b0 || ins_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL jalr_stall: link_we=%b valid=%b want 0 1", link_we, ins_valid);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_rst_link: link_we=%b want 0", link_we);
        end
        @(negedge clk);
        n_checks++;
        if (pc !== RESET_PC || imem_req !== 1'b0 || ins_valid !== 1'b0 || ins !== 32'h0 || link_we !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_rst_state: pc=%h req=%b valid=%b ins=%h lwe=%b want %h 0 0 0 0",
                     pc, imem_req, ins_valid, ins, link_we, RESET_PC);
        end
        rst = 1'b0; clear_ctrl();
        exp_pc = RESET_PC;
    endtask

    task automatic test_midfetch_reset();
        go_to(32'h80);
        wait_fetch();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_drop: req=%b want 0", imem_req);
        end
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || ins_valid !== 1'b0 || ins !== 32'h0 || pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL late_ack: req=%b valid=%b ins=%h pc=%h want 1 0 0 %h", imem_req, ins_valid, ins, pc, RESET_PC);
        end
        exp_pc = RESET_PC;
    endtask

    task automatic test_wrap_and_priority();
        go_to(32'hFFFF_FFFC);
        run_instr(0, 32'h0000_0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h0);
        go_to(32'h300);
        run_instr(0, 32'h0800_0123, 1'b1, BT_BEQ, 1'b1, 1'b0, 1'b0, 32'h9, 32'h9, 0, 1'b1, 32'h48C);
    endtask

    task automatic test_random();
        logic        j;
        logic [31:0] rs;
        for (int i = 0; i < 40; i++) begin
            j  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            run_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom), 3'($urandom_range(0, 7)),
                      j, 1'($urandom), j & 1'($urandom), rs,
                      ($urandom_range(0, 1) == 0) ? rs : $urandom,
                      int'($urandom_range(0, 2)), 1'b0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_branches();
        test_jal();
        test_jalr_stall();
        test_midfetch_reset();
        test_wrap_and_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
